// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave (mode 0) frame receiver for the synth control unit.
// The SPI pins are synchronised into the clk domain and one frame is shifted
// in per chip-select window. A frame of exactly FRAME_BITS bits is committed
// to `frame` with a one-cycle `frame_valid` pulse. Any other non-zero length
// gives a one-cycle `frame_err` pulse.
// Optional feature macro: SPI_RX_ECHO_EN. When it is defined, the last
// committed frame is shifted back out on spi_miso, LSB first, during the
// next window. When it is not defined, spi_miso is tied to 0.
module spi_frame_rx #(
  parameter  int FRAME_BITS  = 2048,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = $clog2(FRAME_BITS + 2)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_csn,
  output logic                  spi_miso,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy,
  output logic [CW-1:0]         bit_count
);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  // Synchroniser chains: the newest sample enters at bit 0, and the last
  // stage is bit SYNC_STAGES-1.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic                   sclk_dly_q;
  logic                   csn_dly_q;

  logic                   sclk_s;
  logic                   mosi_s;
  logic                   csn_s;
  logic                   sclk_rise_s;
  logic                   csn_fall_s;
  logic                   csn_rise_s;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [FRAME_BITS-1:0]  frame_q, frame_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   miso_q, miso_d;

  // Input synchronisers plus one delay flop each for edge detection. The
  // csn chain resets high so that a released reset does not look like a
  // window opening.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_dly_q  <= 1'b0;
      csn_dly_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      csn_dly_q   <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;
  assign csn_fall_s  = ~csn_s & csn_dly_q;
  assign csn_rise_s  = csn_s & ~csn_dly_q;

  // FSM next state, shift register, bit counter and commit decisions.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (csn_fall_s) begin
          sr_d    = '0;
          cnt_d   = CNT_ZERO;
          state_d = S_RECV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RECV: begin
        // A csn rise beats a clock rise seen in the same cycle.
        if (csn_rise_s) begin
          state_d = S_COMMIT;
        end else if (sclk_rise_s) begin
          sr_d = {mosi_s, sr_q[FRAME_BITS-1:1]};
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = S_RECV;
        end
      end
      S_COMMIT: begin
        if (cnt_q == CNT_FULL) begin
          frame_d = sr_q;
          valid_d = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          valid_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RECV);
  end

`ifdef SPI_RX_ECHO_EN
  logic                  sclk_fall_s;
  logic [FRAME_BITS-1:0] echo_q, echo_d;

  assign sclk_fall_s = ~sclk_s & sclk_dly_q;

  // Echo register: load the committed frame when a window opens, and shift
  // it out LSB first on each spi_clk fall. MISO is driven only while csn is low.
  always_comb begin
    echo_d = echo_q;
    if (csn_fall_s) begin
      echo_d = frame_q;
    end else if (sclk_fall_s) begin
      echo_d = {1'b0, echo_q[FRAME_BITS-1:1]};
    end else begin
      echo_d = echo_q;
    end
    if (!csn_s) begin
      miso_d = echo_d[0];
    end else begin
      miso_d = 1'b0;
    end
  end

  // Echo shift register state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      echo_q <= '0;
    end else begin
      echo_q <= echo_d;
    end
  end
`else
  assign miso_d = 1'b0;
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      frame_q <= '0;
      cnt_q   <= CNT_ZERO;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      miso_q  <= miso_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign busy        = busy_q;
  assign bit_count   = cnt_q;
  assign spi_miso    = miso_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomised self-checking bench for spi_frame_rx with FRAME_BITS = 64.
// The reference model keeps the bits sent in each window and the last good frame.
module tb_spi_frame_rx;

  localparam int FB   = 64;
  localparam int SYNC = 2;
  localparam int CW   = $clog2(FB + 2);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_csn = 1'b1;
  logic          spi_miso;
  logic [FB-1:0] frame;
  logic          frame_valid;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] bit_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [FB-1:0] last_frame = '0;

  spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_csn    (spi_csn),
    .spi_miso   (spi_miso),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic all_zero_check(input string tag);
    check(tag, {53'd0, frame, frame_valid, frame_err, busy, bit_count, spi_miso}, 128'd0);
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    spi_csn = 1'b1;
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    all_zero_check("midframe_reset_outputs");
    rstn       = 1'b1;
    last_frame = '0;
    repeat (10) @(negedge clk);
  endtask

  // One chip-select window of n bits, sent LSB first at clk/8.
  // If abort_at is in [0, n), reset is pulsed after abort_at bits.
  task automatic send_window(input logic [127:0] bits, input int n, input int abort_at);
    int fv_cnt, fe_cnt, fv_at, busy_on, busy_off, exp_cnt;
    logic [127:0] miso_v, miso_e;
    bit exp_v, exp_e;
    fv_cnt = 0; fe_cnt = 0; fv_at = 0; busy_on = 0; busy_off = 0;
    miso_v = '0; miso_e = '0;
    spi_csn = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (busy && busy_on == 0) busy_on = k;
    end
    check("busy_rise_cycle", busy_on, SYNC + 1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      spi_mosi = bits[i];
      spi_clk  = 1'b0;
      repeat (4) @(negedge clk);
      miso_v[i] = spi_miso;
      spi_clk  = 1'b1;
      repeat (4) @(negedge clk);
    end
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_csn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (frame_valid) begin fv_cnt++; fv_at = k; end
      if (frame_err) fe_cnt++;
      if (!busy && busy_off == 0) busy_off = k;
    end
    // Model: echo is the previously committed frame, LSB first.
`ifdef SPI_RX_ECHO_EN
    for (int i = 0; i < n; i++) miso_e[i] = (i < FB) ? last_frame[i] : 1'b0;
`endif
    exp_v   = (n == FB);
    exp_e   = (n != 0) && (n != FB);
    exp_cnt = (n > FB + 1) ? FB + 1 : n;
    if (exp_v) last_frame = bits[FB-1:0];
    check("valid_pulses", fv_cnt, exp_v ? 1 : 0);
    check("err_pulses", fe_cnt, exp_e ? 1 : 0);
    if (exp_v) check("valid_latency", fv_at, SYNC + 2);
    check("busy_fall_cycle", busy_off, SYNC + 1);
    check("frame_value", frame, last_frame);
    check("bit_count", bit_count, exp_cnt);
    check("miso_echo", miso_v, miso_e);
    check("miso_idle", spi_miso, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [127:0] pat;
    int n, ab, fv, fe;
    int lens[8] = '{0, 63, 64, 64, 64, 65, 70, 1};

    // Reset while the pins are driven randomly.
    for (int k = 0; k < 10; k++) begin
      spi_clk = 1'($urandom); spi_mosi = 1'($urandom); spi_csn = 1'($urandom);
      @(negedge clk);
    end
    all_zero_check("reset_outputs");
    spi_clk = 1'b0; spi_mosi = 1'b0; spi_csn = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    fv = 0; fe = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_valid) fv++;
      if (frame_err) fe++;
    end
    check("idle_no_pulses", {fv[15:0], fe[15:0]}, 32'd0);

    // Directed windows.
    pat = {64'd0, 64'hDEADBEEF_01234567};
    send_window(pat, 64, -1);
    send_window({64'd0, 64'h0F0F_1234_5678_9ABC}, 63, -1);
    send_window({64'd0, 64'hFFFF_0000_FFFF_0000}, 65, -1);
    send_window(pat, 0, -1);
    send_window({64'd0, 64'h1111_2222_3333_4444}, 64, 30);
    send_window({64'd0, 64'hCAFE_F00D_8765_4321}, 64, -1);
    send_window({64'd0, 64'hA5A5_A5A5_A5A5_A5A5}, 64, -1);
    send_window({$urandom, $urandom, $urandom, $urandom}, 64, -1);

    // Randomised windows.
    for (int t = 0; t < 20; t++) begin
      pat = {$urandom, $urandom, $urandom, $urandom};
      n   = lens[$urandom_range(0, 7)];
      if (n == 1) n = $urandom_range(1, 70);
      ab  = -1;
      if (n > 1 && $urandom_range(0, 5) == 0) ab = $urandom_range(1, n - 1);
      send_window(pat, n, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
